// File: rtl/alu_pkg.sv
// Opcode, FSM state and equalComp field definitions shared by alu_mdu and its bench.
package alu_pkg;

  typedef enum logic [4:0] {
    OP_AND    = 5'b00000,
    OP_OR     = 5'b00001,
    OP_ADD    = 5'b00010,
    OP_XOR    = 5'b00011,
    OP_SLL    = 5'b00100,
    OP_SLT    = 5'b00101,
    OP_SUB    = 5'b00110,
    OP_SLTU   = 5'b00111,
    OP_SRL    = 5'b01000,
    OP_SRA    = 5'b01001,
    OP_MUL    = 5'b10000,
    OP_MULH   = 5'b10001,
    OP_MULHSU = 5'b10010,
    OP_MULHU  = 5'b10011,
    OP_DIV    = 5'b10100,
    OP_DIVU   = 5'b10101,
    OP_REM    = 5'b10110,
    OP_REMU   = 5'b10111
  } alu_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_FIX  = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  localparam int EQC_EN = 0;
  localparam int EQC_EQ = 1;

  // Multiply/divide group is 10xxx; 11xxx codes are unused and fall to base decode.
  function automatic logic is_mdu_op(input logic [4:0] code);
    return code[4:3] == 2'b10;
  endfunction

endpackage

// File: rtl/alu_mdu_iter.sv
// Shared radix-2 multiply / restoring-divide datapath: accumulator, shift register, operand and counter.
module alu_mdu_iter #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic            step,
  input  logic            is_div,
  input  logic [XLEN-1:0] init_lo,
  input  logic [XLEN-1:0] init_opd,
  output logic [XLEN-1:0] hi,
  output logic [XLEN-1:0] lo,
  output logic            last
);

  localparam int CW = $clog2(XLEN);

  logic [XLEN:0]   acc;
  logic [XLEN-1:0] opd;
  logic [CW-1:0]   cnt;
  logic [XLEN:0]   mul_sum;
  logic [XLEN:0]   rem_sh;
  logic [XLEN:0]   rem_diff;

  // Multiply: lo holds the multiplier, product shifts right into lo.
  // Divide: lo holds the dividend, quotient bits shift in from the right.
  always_comb begin
    mul_sum  = {1'b0, acc[XLEN-1:0]} + {1'b0, opd};
    rem_sh   = {acc[XLEN-1:0], lo[XLEN-1]};
    rem_diff = rem_sh - {1'b0, opd};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc <= '0;
      lo  <= '0;
      opd <= '0;
      cnt <= '0;
    end else if (start) begin
      acc <= '0;
      lo  <= init_lo;
      opd <= init_opd;
      cnt <= CW'(XLEN - 1);
    end else if (step) begin
      cnt <= cnt - CW'(1);
      if (is_div) begin
        if (!rem_diff[XLEN]) begin
          acc <= rem_diff;
          lo  <= {lo[XLEN-2:0], 1'b1};
        end else begin
          acc <= rem_sh;
          lo  <= {lo[XLEN-2:0], 1'b0};
        end
      end else if (lo[0]) begin
        {acc, lo} <= {1'b0, mul_sum, lo[XLEN-1:1]};
      end else begin
        {acc, lo} <= {1'b0, acc, lo[XLEN-1:1]};
      end
    end
  end

  assign hi   = acc[XLEN-1:0];
  assign last = (cnt == '0);

endmodule

// File: rtl/alu_mdu.sv
// ALU with iterative M-extension unit: decode, single-cycle base ops, sequencing FSM and output registers.
//   state | meaning
//   IDLE  | waiting for a request
//   CALC  | one mul/div iteration per cycle, XLEN cycles
//   FIX   | apply signs / special cases, load result
//   DONE  | out_valid pulse; may accept the next request
module alu_mdu
  import alu_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int SHW  = $clog2(XLEN)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [4:0]      alu_control,
  input  logic [XLEN-1:0] src_a,
  input  logic [XLEN-1:0] src_b,
  input  logic [1:0]      equalComp,
  input  logic            flush,
  output logic            out_valid,
  output logic [XLEN-1:0] result,
  output logic            zero
);

  state_e state, state_nxt;
  alu_op_e op_in, op_q;

  logic            run;
  logic            accept, base_acc, m_acc, step, finish;
  logic            is_m_in;
  logic            a_signed, b_signed, a_neg, b_neg;
  logic [XLEN-1:0] a_mag, b_mag;
  logic [SHW-1:0]  shamt;
  logic [XLEN-1:0] base_res;
  logic            base_zero;
  logic            cmp_en, cmp_eq;

  logic [XLEN-1:0] a_q;
  logic            b_zero_q, neg_q, neg_rem_q;

  logic [XLEN-1:0]   it_hi, it_lo;
  logic              it_last;
  logic [2*XLEN-1:0] prod;
  logic [XLEN-1:0]   quo, rmd, fix_res;

  assign op_in   = alu_op_e'(alu_control);
  assign is_m_in = is_mdu_op(alu_control);
  assign shamt   = src_b[SHW-1:0];
  assign cmp_en  = equalComp[EQC_EN];
  assign cmp_eq  = equalComp[EQC_EQ];

  always_comb begin
    base_res  = '0;
    base_zero = 1'b0;
    case (op_in)
      OP_AND:  base_res = src_a & src_b;
      OP_OR:   base_res = src_a | src_b;
      OP_ADD:  base_res = src_a + src_b;
      OP_XOR:  base_res = src_a ^ src_b;
      OP_SLL:  base_res = src_a << shamt;
      OP_SLT:  base_res = {{(XLEN-1){1'b0}}, ($signed(src_a) < $signed(src_b))};
      OP_SUB:  base_res = src_a - src_b;
      OP_SLTU: base_res = {{(XLEN-1){1'b0}}, (src_a < src_b)};
      OP_SRL:  base_res = src_a >> shamt;
      OP_SRA:  base_res = $signed(src_a) >>> shamt;
      default: base_res = '0;
    endcase
    case (op_in)
      OP_SUB:  base_zero = (base_res == '0);
      OP_XOR:  base_zero = cmp_en && (cmp_eq ? (base_res == '0) : (base_res != '0));
      OP_SLT,
      OP_SLTU: base_zero = cmp_en && (cmp_eq ? (base_res != '0) : (base_res == '0));
      default: base_zero = 1'b0;
    endcase
  end

  // The iterative core works on magnitudes; signs are remembered for the fix-up.
  always_comb begin
    a_signed = (op_in == OP_MULH) || (op_in == OP_MULHSU) || (op_in == OP_DIV) || (op_in == OP_REM);
    b_signed = (op_in == OP_MULH) || (op_in == OP_DIV) || (op_in == OP_REM);
    a_neg    = a_signed && src_a[XLEN-1];
    b_neg    = b_signed && src_b[XLEN-1];
    a_mag    = a_neg ? -src_a : src_a;
    b_mag    = b_neg ? -src_b : src_b;
  end

  always_comb begin
    state_nxt = state;
    step      = 1'b0;
    finish    = 1'b0;
    in_ready  = run && ((state == ST_IDLE) || (state == ST_DONE));
    accept    = in_valid && in_ready && !flush;
    case (state)
      ST_IDLE, ST_DONE: begin
        if (accept) state_nxt = is_m_in ? ST_CALC : ST_DONE;
        else        state_nxt = ST_IDLE;
      end
      ST_CALC: begin
        step = 1'b1;
        if (it_last) state_nxt = ST_FIX;
      end
      ST_FIX: begin
        finish    = 1'b1;
        state_nxt = ST_DONE;
      end
      default: state_nxt = ST_IDLE;
    endcase
    if (flush) begin
      state_nxt = ST_IDLE;
      step      = 1'b0;
      finish    = 1'b0;
    end
  end

  assign base_acc = accept && !is_m_in;
  assign m_acc    = accept && is_m_in;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  alu_mdu_iter #(.XLEN(XLEN)) u_iter (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (m_acc),
    .step     (step),
    .is_div   (op_q[2]),
    .init_lo  (a_mag),
    .init_opd (b_mag),
    .hi       (it_hi),
    .lo       (it_lo),
    .last     (it_last)
  );

  // Divide-by-zero overrides the raw quotient/remainder; min/-1 falls out of the magnitude path.
  always_comb begin
    prod = {it_hi, it_lo};
    if (neg_q) prod = -prod;
    quo = neg_q ? -it_lo : it_lo;
    rmd = neg_rem_q ? -it_hi : it_hi;
    if (b_zero_q) begin
      quo = '1;
      rmd = a_q;
    end
    case (op_q)
      OP_MUL:                       fix_res = prod[XLEN-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU: fix_res = prod[2*XLEN-1:XLEN];
      OP_DIV, OP_DIVU:              fix_res = quo;
      default:                      fix_res = rmd;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run       <= 1'b0;
      out_valid <= 1'b0;
      result    <= '0;
      zero      <= 1'b0;
      op_q      <= OP_AND;
      a_q       <= '0;
      b_zero_q  <= 1'b0;
      neg_q     <= 1'b0;
      neg_rem_q <= 1'b0;
    end else begin
      run       <= 1'b1;
      out_valid <= base_acc || finish;
      if (base_acc) begin
        result <= base_res;
        zero   <= base_zero;
      end else if (finish) begin
        result <= fix_res;
        zero   <= 1'b0;
      end
      if (m_acc) begin
        op_q      <= op_in;
        a_q       <= src_a;
        b_zero_q  <= (src_b == '0);
        neg_q     <= a_neg ^ b_neg;
        neg_rem_q <= a_neg;
      end
    end
  end

endmodule

// File: tb/tb_alu_mdu.sv
// Directed bench for alu_mdu (XLEN=32) with hand-computed expected results.
module tb_alu_mdu;
  import alu_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [4:0]  alu_control = 5'd0;
  logic [31:0] src_a = '0;
  logic [31:0] src_b = '0;
  logic [1:0]  equalComp = 2'b00;
  logic        flush = 1'b0;
  logic        out_valid;
  logic [31:0] result;
  logic        zero;

  int checks = 0;
  int errors = 0;

  alu_mdu #(.XLEN(32)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .alu_control (alu_control),
    .src_a       (src_a),
    .src_b       (src_b),
    .equalComp   (equalComp),
    .flush       (flush),
    .out_valid   (out_valid),
    .result      (result),
    .zero        (zero)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  // Called just after a rising edge while in_ready is high.
  task automatic run_op(input string tag, input logic [4:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [1:0] eqc,
                        input logic [31:0] exp_res, input logic exp_zero, input int exp_lat);
    int lat;
    alu_control = op; src_a = a; src_b = b; equalComp = eqc; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    check({tag, " lat"}, lat, exp_lat);
    check({tag, " res"}, result, exp_res);
    check({tag, " zero"}, {31'd0, zero}, {31'd0, exp_zero});
  endtask

  task automatic watch_quiet(input string tag, input int cycles);
    int seen;
    seen = 0;
    for (int i = 0; i < cycles; i++) begin
      if (out_valid) seen++;
      @(posedge clk); #1;
    end
    check({tag, " no out_valid"}, seen, 0);
  endtask

  initial begin
    #1;
    check("rst in_ready", {31'd0, in_ready}, 0);
    check("rst out_valid", {31'd0, out_valid}, 0);
    check("rst result", result, 0);
    check("rst zero", {31'd0, zero}, 0);
    #21;
    rst_n = 1'b1;
    #1;
    check("rel pre-edge in_ready", {31'd0, in_ready}, 0);
    @(posedge clk); #1;
    check("rel in_ready", {31'd0, in_ready}, 1);

    // ADD then SUB back to back
    alu_control = OP_ADD; src_a = 32'd5; src_b = 32'd7; equalComp = 2'b00; in_valid = 1'b1;
    @(posedge clk); #1;
    alu_control = OP_SUB; src_a = 32'd3; src_b = 32'd3;
    check("b2b1 valid", {31'd0, out_valid}, 1);
    check("b2b1 res", result, 32'd12);
    check("b2b1 zero", {31'd0, zero}, 0);
    check("b2b1 ready", {31'd0, in_ready}, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("b2b2 valid", {31'd0, out_valid}, 1);
    check("b2b2 res", result, 32'd0);
    check("b2b2 zero", {31'd0, zero}, 1);
    @(posedge clk); #1;
    check("pulse end", {31'd0, out_valid}, 0);
    check("hold res", result, 32'd0);
    check("hold zero", {31'd0, zero}, 1);

    run_op("and",   OP_AND,  32'hF0, 32'h3C, 2'b00, 32'h30, 1'b0, 1);
    run_op("or",    OP_OR,   32'hF0, 32'h0F, 2'b00, 32'hFF, 1'b0, 1);
    run_op("add0",  OP_ADD,  32'hFFFF_FFFF, 32'd1, 2'b00, 32'd0, 1'b0, 1);
    run_op("sub",   OP_SUB,  32'd5, 32'd3, 2'b00, 32'd2, 1'b0, 1);
    run_op("sll",   OP_SLL,  32'd1, 32'h24, 2'b00, 32'h10, 1'b0, 1);
    run_op("srl",   OP_SRL,  32'h8000_0000, 32'd4, 2'b00, 32'h0800_0000, 1'b0, 1);
    run_op("sra",   OP_SRA,  32'h8000_0000, 32'h21, 2'b00, 32'hC000_0000, 1'b0, 1);
    run_op("xoreq", OP_XOR,  32'd4, 32'd4, 2'b01, 32'd0, 1'b0, 1);
    run_op("xor11", OP_XOR,  32'd4, 32'd4, 2'b11, 32'd0, 1'b1, 1);
    run_op("xorne", OP_XOR,  32'd4, 32'd5, 2'b11, 32'd1, 1'b0, 1);
    run_op("sltu",  OP_SLTU, 32'hFFFF_FFFF, 32'd1, 2'b01, 32'd0, 1'b1, 1);
    run_op("slt00", OP_SLT,  32'hFFFF_FFFF, 32'd1, 2'b00, 32'd1, 1'b0, 1);
    run_op("slt11", OP_SLT,  32'hFFFF_FFFF, 32'd1, 2'b11, 32'd1, 1'b1, 1);
    run_op("bad",   5'b11000, 32'd9, 32'd9, 2'b11, 32'd0, 1'b0, 1);

    run_op("mulh",   OP_MULH,   32'h8000_0000, 32'h8000_0000, 2'b00, 32'h4000_0000, 1'b0, 34);
    run_op("mulhu",  OP_MULHU,  32'hFFFF_FFFF, 32'd2, 2'b00, 32'h0000_0001, 1'b0, 34);
    run_op("mulhu2", OP_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 2'b00, 32'hFFFF_FFFE, 1'b0, 34);
    run_op("mulhn",  OP_MULH,   32'hFFFF_FFFF, 32'hFFFF_FFFF, 2'b00, 32'h0, 1'b0, 34);
    run_op("mul",    OP_MUL,    32'hFFFF_FFFD, 32'd5, 2'b00, 32'hFFFF_FFF1, 1'b0, 34);
    run_op("mulhsu", OP_MULHSU, 32'hFFFF_FFFF, 32'd2, 2'b00, 32'hFFFF_FFFF, 1'b0, 34);
    run_op("div",    OP_DIV,    32'hFFFF_FFF9, 32'd2, 2'b00, 32'hFFFF_FFFD, 1'b0, 34);
    run_op("rem",    OP_REM,    32'hFFFF_FFF9, 32'd2, 2'b00, 32'hFFFF_FFFF, 1'b0, 34);
    run_op("divu",   OP_DIVU,   32'hFFFF_FFF9, 32'd2, 2'b00, 32'h7FFF_FFFC, 1'b0, 34);
    run_op("remu",   OP_REMU,   32'hFFFF_FFF9, 32'd2, 2'b00, 32'd1, 1'b0, 34);
    run_op("divu0",  OP_DIVU,   32'd9, 32'd0, 2'b00, 32'hFFFF_FFFF, 1'b0, 34);
    run_op("remu0",  OP_REMU,   32'd9, 32'd0, 2'b00, 32'd9, 1'b0, 34);
    run_op("div0",   OP_DIV,    32'd7, 32'd0, 2'b00, 32'hFFFF_FFFF, 1'b0, 34);
    run_op("rem0",   OP_REM,    32'hFFFF_FFF9, 32'd0, 2'b00, 32'hFFFF_FFF9, 1'b0, 34);
    run_op("divov",  OP_DIV,    32'h8000_0000, 32'hFFFF_FFFF, 2'b00, 32'h8000_0000, 1'b0, 34);
    run_op("remov",  OP_REM,    32'h8000_0000, 32'hFFFF_FFFF, 2'b00, 32'd0, 1'b0, 34);
    run_op("slt_l",  OP_SLT,    32'hFFFF_FFFF, 32'd1, 2'b11, 32'd1, 1'b1, 1);

    // flush beats a simultaneous accept
    alu_control = OP_ADD; src_a = 32'd1; src_b = 32'd1; in_valid = 1'b1; flush = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; flush = 1'b0;
    check("flacc valid", {31'd0, out_valid}, 0);
    check("flacc hold", result, 32'd1);

    // flush mid-divide
    alu_control = OP_DIVU; src_a = 32'd100; src_b = 32'd3; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("fl busy ready", {31'd0, in_ready}, 0);
    repeat (3) begin @(posedge clk); #1; end
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    check("fl ready", {31'd0, in_ready}, 1);
    watch_quiet("fl", 40);

    // reset mid-divide
    alu_control = OP_DIVU; src_a = 32'd100; src_b = 32'd3; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (8) begin @(posedge clk); #1; end
    #2 rst_n = 1'b0;
    #1;
    check("mrst ready", {31'd0, in_ready}, 0);
    check("mrst valid", {31'd0, out_valid}, 0);
    check("mrst res", result, 32'd0);
    check("mrst zero", {31'd0, zero}, 0);
    @(posedge clk); #3;
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("mrst rel ready", {31'd0, in_ready}, 1);
    watch_quiet("mrst", 40);

    run_op("post", OP_ADD, 32'd20, 32'd22, 2'b00, 32'd42, 1'b0, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
